// File: rtl/div5_word_serializer_pkg.sv
// Shared constants for the word-level divide-by-5 serializer.
package div5_word_serializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Legacy state encoding, kept as plain constants for compatibility.
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CLEAR   = 2'd1;
    localparam logic [1:0] SHIFT   = 2'd2;
    localparam logic [1:0] CAPTURE = 2'd3;

endpackage

// File: rtl/div5_word_serializer.sv
// Feeds parallel words MSB-first into an external serial divide-by-5 checker.
// The checker is cleared before each word, and its flag is sampled after the last bit.
module div5_word_serializer
    import div5_word_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             chk_clear,
    input  logic             div_in,
    output logic             res_valid,
    output logic             res_div5,
    output logic [WIDTH-1:0] res_data
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]       state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] data_reg;
    logic [CW-1:0]    cnt;
    logic             accept;

    assign accept = in_valid && in_ready;

    // FSM plus the shift/count datapath; a word is latched in IDLE or CAPTURE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            data_reg  <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg <= in_data;
                        data_reg  <= in_data;
                        cnt       <= CW'(WIDTH - 1);
                        state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    state <= SHIFT;
                end
                SHIFT: begin
                    shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                    cnt       <= cnt - CW'(1);
                    if (cnt == '0) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // Accepting here skips IDLE to sustain one word per WIDTH+2 cycles.
                    if (accept) begin
                        shift_reg <= in_data;
                        data_reg  <= in_data;
                        cnt       <= CW'(WIDTH - 1);
                        state     <= CLEAR;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output decode; results are suppressed while reset is held so a dropped word never reports.
    always_comb begin
        in_ready  = (state == IDLE) || (state == CAPTURE);
        bit_valid = (state == SHIFT);
        bit_out   = (state == SHIFT) ? shift_reg[WIDTH-1] : 1'b0;
        chk_clear = reset || (state == CLEAR);
        res_valid = (state == CAPTURE) && !reset;
        res_div5  = (state == CAPTURE) && !reset && div_in;
        res_data  = data_reg;
    end

endmodule

// File: tb/tb_div5_word_serializer.sv
// Scoreboard bench for div5_word_serializer paired with a behavioural serial mod-5 checker.
module tb_div5_word_serializer;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] data;
        bit           div;
        int           e;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         bit_out;
    logic         bit_valid;
    logic         chk_clear;
    logic         div_in;
    logic         res_valid;
    logic         res_div5;
    logic [W-1:0] res_data;

    int   errors  = 0;
    int   checks  = 0;
    int   cyc     = 0;
    int   acc_cnt = 0;
    bit   started = 0;
    int   rem     = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    div5_word_serializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .chk_clear (chk_clear),
        .div_in    (div_in),
        .res_valid (res_valid),
        .res_div5  (res_div5),
        .res_data  (res_data)
    );

    // Serial divide-by-5 checker: running remainder of the MSB-first bit stream.
    always @(posedge clk) begin
        if (chk_clear) rem <= 0;
        else           rem <= (rem * 2 + int'(bit_out)) % 5;
    end
    assign div_in = (rem == 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Ready whenever no word is in flight, or the in-flight word is in its result cycle.
    function automatic bit model_ready(input int c);
        if (q.size() == 0) return 1'b1;
        return c >= q[$].due;
    endfunction

    // Edge n ends cycle n-1; an accept at edge E produces its result in cycle E+W+1.
    always @(posedge clk) begin
        exp_t t;
        cyc = cyc + 1;
        if (reset) begin
            q.delete();
            started = 1'b1;
        end else if (started && in_valid && model_ready(cyc - 1)) begin
            t.data = in_data;
            t.div  = (int'(in_data) % 5 == 0);
            t.e    = cyc;
            t.due  = cyc + W + 1;
            q.push_back(t);
            acc_cnt++;
        end
    end

    // Monitor: per-cycle output expectations and in-order result scoreboard.
    always @(negedge clk) begin
        int           c;
        int           e;
        bit           act;
        bit           exp_rv;
        bit           exp_bv;
        bit           exp_bo;
        bit           exp_cc;
        logic [W-1:0] w;
        if (started) begin
            c      = cyc;
            act    = (q.size() > 0);
            e      = act ? q[$].e : 0;
            w      = act ? q[$].data : '0;
            exp_cc = reset || (act && c == e);
            exp_bv = act && (c > e) && (c <= e + W);
            exp_bo = exp_bv ? w[W - (c - e)] : 1'b0;
            exp_rv = act && (q[0].due == c) && !reset;
            chk("in_ready",  in_ready,  model_ready(c));
            chk("chk_clear", chk_clear, exp_cc);
            chk("bit_valid", bit_valid, exp_bv);
            chk("bit_out",   bit_out,   exp_bo);
            chk("res_valid", res_valid, exp_rv);
            if (exp_rv) begin
                if (res_valid) begin
                    chk("res_div5", res_div5, q[0].div);
                    chk("res_data", res_data, q[0].data);
                end
                void'(q.pop_front());
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input bit drop_after);
        int start = acc_cnt;
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (acc_cnt == start && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (acc_cnt == start) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept of %0d", d);
        end
        if (drop_after) in_valid = 1'b0;
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data",  res_data,  0);
        chk("rst_chk_clear", chk_clear, 1);
        chk("rst_bit_valid", bit_valid, 0);
        chk("rst_in_ready",  in_ready,  1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed words.
        send(8'd10, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        send(8'd7, 1'b1);
        send(8'd0, 1'b1);
        send(8'd255, 1'b1);
        repeat (12) @(posedge clk);
        #1;

        // Back-to-back with valid held high.
        send(8'd25, 1'b0);
        send(8'd26, 1'b1);
        repeat (12) @(posedge clk);
        #1;

        // Exhaustive, back-to-back.
        for (int v = 0; v < 256; v++) send(W'(v), v == 255);
        repeat (12) @(posedge clk);
        #1;

        // Reset in the 4th SHIFT cycle of word 15.
        send(8'd15, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("ready_after_reset", in_ready, 1);
        send(8'd20, 1'b1);
        repeat (12) @(posedge clk);
        #1;

        // Valid toggling and data churning every cycle.
        in_valid = 1'b1;
        in_data  = W'($urandom);
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom_range(0, 1));
            in_data  = W'($urandom);
        end
        in_valid = 1'b0;

        // Random words with random idle gaps.
        for (int i = 0; i < 30; i++) begin
            send(W'($urandom), 1'b1);
            repeat ($urandom_range(0, 12)) @(posedge clk);
            #1;
        end

        // Drain outstanding results.
        n = 0;
        while (q.size() > 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
